platform_led: RTL
=================

# platform_led

Avalon-MM slave output port: the write-side counterpart of the platform switch input port. It drives a 10-bit LED bank from a CPU-writable data register. It adds atomic bit set/clear and a hardware blink engine with a programmable period. It sits on the Qsys interconnect beside the switch PIO and uses the same read timing: 1-cycle registered read latency, no wait states.

## Interface
- DATA_WIDTH, 10, width of out_port and of the data/mask registers
- PERIOD_WIDTH, 24, width of the blink half-period register and counter
- RESET_VALUE, 0, reset value of the data register
- clk  in  1  system clock; all logic on rising edge
- reset_n  in  1  asynchronous, active-low reset
- address  in  3  word address of register
- chipselect  in  1  slave select
- write_n  in  1  active-low write strobe; write = chipselect & ~write_n
- writedata  in  32  write data
- readdata  out  32  registered read data; reset 0
- out_port  out  DATA_WIDTH  LED drive, registered; reset RESET_VALUE

## Operation
- Register map (word address):
  - 0 DATA, read/write
  - 1 BLINK_MASK, read/write
  - 2 PERIOD, read/write
  - 3 STATUS, read-only: bit31 = phase, bits[PERIOD_WIDTH-1:0] = counter
  - 4 OUTSET, write-only
  - 5 OUTCLEAR, write-only
  - 6, 7 reserved
- Register updates on a write:
  - DATA takes writedata[DATA_WIDTH-1:0].
  - OUTSET: data |= writedata[DATA_WIDTH-1:0].
  - OUTCLEAR: data &= ~writedata[DATA_WIDTH-1:0].
  - MASK takes writedata[DATA_WIDTH-1:0].
  - PERIOD takes writedata[PERIOD_WIDTH-1:0]; higher bits are ignored.
- Reset values: data = RESET_VALUE, mask = 0, period = 0, counter = 0, phase = 1.
- Blink engine, two states:
  - IDLE when period == 0. Counter is held at 0 and phase is held at 1.
  - RUN when period != 0. Counter increments every cycle. When counter == period-1, counter wraps to 0 and phase toggles.
- Any PERIOD write, including a write of the same value, clears the counter to 0 and sets phase to 1. This takes priority over a wrap in the same cycle.
- out_port next value = data & ~(mask & {DATA_WIDTH{~phase}}). Masked bits therefore follow data while phase = 1 and are forced off while phase = 0.
- readdata is updated every cycle from address, regardless of chipselect, with unused upper bits zero-filled.
  - Addresses 0–3 return the registers above.
  - Addresses 4–7 return 0.
- Writes to addresses 3, 6 and 7 are ignored.

## Timing
- Write accepted on clock edge N; the target register holds its new value after edge N.
- out_port reflects that write after edge N+1. Latency: 1 cycle from the register update.
- Read: address presented before edge N produces readdata valid after edge N (latency 1). No waitrequest.
- Read of DATA in the cycle of a write to DATA returns the old value.
- Blink timing:
  - Phase toggles every `period` cycles, so a full blink cycle is 2*period clocks.
  - period = 1 toggles phase every cycle.
  - period = 2^PERIOD_WIDTH-1 is the maximum; no overflow is possible because the counter wraps at period-1.
- Reduction of period below the current counter value cannot occur: the PERIOD write itself resets the counter.
- Asynchronous reset mid-operation immediately forces all registers and outputs to their reset values. Blinking resumes only after PERIOD is rewritten.

## Structure
- Shared package platform_led_pkg holds:
  - address constants ADDR_DATA=0, ADDR_MASK=1, ADDR_PERIOD=2, ADDR_STATUS=3, ADDR_OUTSET=4, ADDR_OUTCLEAR=5
  - STATUS_PHASE_BIT=31
- One sub-module, platform_led_blink_timer, holds period, counter and phase.
  - Inputs: period_wr, period_in.
  - Outputs: period, counter, phase.
- The top level holds the register decode, the data/mask registers, the readdata mux and the out_port register.

## Test plan
- Reset: assert reset_n=0 mid-write → readdata=0 and out_port=0 asynchronously. STATUS reads 0x80000000 after release.
- Write DATA=0x3FF, then OUTCLEAR=0x00F, then OUTSET=0x001 → DATA readback 0x3F1. out_port=0x3F1 one cycle after the last write.
- Write DATA=0x0FF, MASK=0x00F, PERIOD=4 → out_port alternates 0x0FF / 0x0F0 with exactly 4 clocks per phase. STATUS counter sequences 0,1,2,3,0.
- Rewrite PERIOD=4 in the same cycle the counter would wrap → counter returns to 0 and phase returns to 1, with no toggle in that cycle.
- Write PERIOD=0 while running → phase=1, counter=0, and out_port=DATA steady for 100 cycles.
- Write 0xFFFFFFFF to address 3 and address 6 → no register changes. Reads of addresses 4–7 return 0.

Source files
------------

// File: rtl/platform_led_pkg.sv
// ---------------------------------------------------------------------------
// platform_led_pkg
// Shared definitions for the LED output port: register word addresses,
// the STATUS phase bit position and the blink engine state type.
// ---------------------------------------------------------------------------
package platform_led_pkg;

    localparam logic [2:0] ADDR_DATA     = 3'd0;
    localparam logic [2:0] ADDR_MASK     = 3'd1;
    localparam logic [2:0] ADDR_PERIOD   = 3'd2;
    localparam logic [2:0] ADDR_STATUS   = 3'd3;
    localparam logic [2:0] ADDR_OUTSET   = 3'd4;
    localparam logic [2:0] ADDR_OUTCLEAR = 3'd5;

    localparam int STATUS_PHASE_BIT = 31;

    typedef enum logic {
        BLINK_IDLE = 1'b0,
        BLINK_RUN  = 1'b1
    } blink_state_e;

endpackage

// File: rtl/platform_led_if.sv
// ---------------------------------------------------------------------------
// platform_led_if
// Avalon-MM slave bus bundle for the LED port.
//   address    word address (3 bits)
//   chipselect slave select
//   write_n    active-low write strobe
//   writedata  32-bit write data
//   readdata   32-bit registered read data (driven by the slave)
// ---------------------------------------------------------------------------
interface platform_led_if;

    logic [2:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;

    modport master (
        output address,
        output chipselect,
        output write_n,
        output writedata,
        input  readdata
    );

    modport slave (
        input  address,
        input  chipselect,
        input  write_n,
        input  writedata,
        output readdata
    );

endinterface

// File: rtl/platform_led_blink_timer.sv
// ---------------------------------------------------------------------------
// platform_led_blink_timer
// Holds the blink half-period, the free-running counter and the blink phase.
//   clk, reset_n  clock and asynchronous active-low reset
//   period_wr     load period_in, restart the counter, force phase high
//   period_in     new half-period (0 stops blinking)
//   period        current half-period register
//   counter       cycle counter within the current half-period
//   phase         1 = masked LEDs follow data, 0 = masked LEDs forced off
// ---------------------------------------------------------------------------
module platform_led_blink_timer
    import platform_led_pkg::*;
#(
    parameter int PERIOD_WIDTH = 24
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    period_wr,
    input  logic [PERIOD_WIDTH-1:0] period_in,
    output logic [PERIOD_WIDTH-1:0] period,
    output logic [PERIOD_WIDTH-1:0] counter,
    output logic                    phase
);

    blink_state_e            r_state;
    logic [PERIOD_WIDTH-1:0] r_period;
    logic [PERIOD_WIDTH-1:0] r_counter;
    logic                    r_phase;

    // A PERIOD write wins over a wrap in the same cycle, so it is tested first.
    // The state is decided from the written value, which keeps period-1 from
    // ever being evaluated with period == 0 while running.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state   <= BLINK_IDLE;
            r_period  <= '0;
            r_counter <= '0;
            r_phase   <= 1'b1;
        end else if (period_wr) begin
            r_state   <= (period_in == '0) ? BLINK_IDLE : BLINK_RUN;
            r_period  <= period_in;
            r_counter <= '0;
            r_phase   <= 1'b1;
        end else begin
            case (r_state)
                BLINK_IDLE: begin
                    r_counter <= '0;
                    r_phase   <= 1'b1;
                end
                BLINK_RUN: begin
                    if (r_counter == r_period - PERIOD_WIDTH'(1)) begin
                        r_counter <= '0;
                        r_phase   <= ~r_phase;
                    end else begin
                        r_counter <= r_counter + PERIOD_WIDTH'(1);
                    end
                end
                default: begin
                    r_state   <= BLINK_IDLE;
                    r_counter <= '0;
                    r_phase   <= 1'b1;
                end
            endcase
        end
    end

    assign period  = r_period;
    assign counter = r_counter;
    assign phase   = r_phase;

endmodule

// File: rtl/platform_led.sv
// ---------------------------------------------------------------------------
// platform_led
// Avalon-MM LED output port with atomic set/clear and a blink engine.
//   clk, reset_n  clock and asynchronous active-low reset
//   bus           Avalon-MM slave (address, chipselect, write_n, writedata,
//                 readdata with 1-cycle registered latency, no wait states)
//   out_port      registered LED drive
// ---------------------------------------------------------------------------
module platform_led
    import platform_led_pkg::*;
#(
    parameter int                    DATA_WIDTH   = 10,
    parameter int                    PERIOD_WIDTH = 24,
    parameter logic [DATA_WIDTH-1:0] RESET_VALUE  = '0
) (
    input  logic                  clk,
    input  logic                  reset_n,
    platform_led_if.slave         bus,
    output logic [DATA_WIDTH-1:0] out_port
);

    logic [DATA_WIDTH-1:0]   r_data;
    logic [DATA_WIDTH-1:0]   r_mask;
    logic [DATA_WIDTH-1:0]   r_outPort;
    logic [31:0]             r_readData;
    logic [31:0]             w_readNext;
    logic                    w_write;
    logic                    w_periodWr;
    logic [DATA_WIDTH-1:0]   w_wrData;
    logic [PERIOD_WIDTH-1:0] w_period;
    logic [PERIOD_WIDTH-1:0] w_counter;
    logic                    w_phase;

    // Upper write-data bits beyond the period field carry no meaning.
    wire w_unusedBits = &{1'b0, bus.writedata[31:PERIOD_WIDTH]};

    assign w_write    = bus.chipselect & ~bus.write_n;
    assign w_periodWr = w_write && (bus.address == ADDR_PERIOD);
    assign w_wrData   = bus.writedata[DATA_WIDTH-1:0];

    platform_led_blink_timer #(
        .PERIOD_WIDTH (PERIOD_WIDTH)
    ) u_blink_timer (
        .clk       (clk),
        .reset_n   (reset_n),
        .period_wr (w_periodWr),
        .period_in (bus.writedata[PERIOD_WIDTH-1:0]),
        .period    (w_period),
        .counter   (w_counter),
        .phase     (w_phase)
    );

    // DATA/MASK register file; STATUS and reserved addresses fall through.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_data <= RESET_VALUE;
            r_mask <= '0;
        end else if (w_write) begin
            case (bus.address)
                ADDR_DATA:     r_data <= w_wrData;
                ADDR_MASK:     r_mask <= w_wrData;
                ADDR_OUTSET:   r_data <= r_data | w_wrData;
                ADDR_OUTCLEAR: r_data <= r_data & ~w_wrData;
                default: ;
            endcase
        end
    end

    // Read mux is evaluated every cycle regardless of chipselect.
    always_comb begin
        w_readNext = '0;
        case (bus.address)
            ADDR_DATA:   w_readNext[DATA_WIDTH-1:0]   = r_data;
            ADDR_MASK:   w_readNext[DATA_WIDTH-1:0]   = r_mask;
            ADDR_PERIOD: w_readNext[PERIOD_WIDTH-1:0] = w_period;
            ADDR_STATUS: begin
                w_readNext[PERIOD_WIDTH-1:0] = w_counter;
                w_readNext[STATUS_PHASE_BIT] = w_phase;
            end
            default: ;
        endcase
    end

    // Masked bits are blanked during the low blink phase; the output lags the
    // registers by one cycle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_readData <= '0;
            r_outPort  <= RESET_VALUE;
        end else begin
            r_readData <= w_readNext;
            r_outPort  <= r_data & ~(r_mask & {DATA_WIDTH{~w_phase}});
        end
    end

    assign bus.readdata = r_readData;
    assign out_port     = r_outPort;

endmodule
